ps2_kbd_ctrl: RTL
=================

Name: ps2_kbd_ctrl

Overview:
- Sequencer/decoder sitting directly behind the PS/2 keyboard receiver FIFO.
- Pops raw scan-code bytes with a one-cycle nextdata pulse and folds Set-2 prefixes (E0 extended, F0 break) into single key events.
- Tracks shift and held-key state and emits ASCII plus a press counter to the display/console logic.

Parameters:
- CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.
- PFX_TIMEOUT, 16'd50000, max clk cycles a pending E0/F0 prefix waits for its code byte before being discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- kbd_ready  in  1  receiver FIFO non-empty.
- kbd_data  in  8  receiver FIFO head byte.
- kbd_overflow  in  1  receiver sticky overflow.
- kbd_nextdata  out  1  one-cycle pop pulse to receiver.
- key_valid  out  1  one-cycle event strobe.
- key_code  out  8  scan code of event (prefixes stripped).
- key_ext  out  1  event had E0 prefix.
- key_break  out  1  event is release (F0).
- key_repeat  out  1  make of already-held key (typematic).
- key_ascii  out  8  ASCII of make event, 0 if none/extended/break.
- key_held  out  1  a non-modifier key is currently down.
- press_count  out  CNT_W  number of non-repeat, non-modifier make events.
- err  out  1  sticky: overflow seen or error byte 00/FF received.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM=IDLE, prefix flags/shift/held cleared, timeout counter 0.
- FSM: IDLE, POP, GAP.
- IDLE: if kbd_ready, latch kbd_data into byte_r, go POP; else stay.
- POP (1 cycle): kbd_nextdata=1, decode byte_r, go GAP.
- GAP (1 cycle): kbd_nextdata=0 so the receiver's registered ready settles, then go IDLE.
- Result: kbd_nextdata is never high two consecutive cycles; max rate 1 byte / 3 cycles.
- Decode of byte_r in POP, event outputs registered and visible the cycle after POP:
  - E0: set pend_ext, no event.
  - F0: set pend_brk, no event.
  - 00 or FF: set err, clear both flags, no event.
  - FA, AA, E1: discard silently, clear flags.
  - Any other byte: key_valid=1, key_code=byte_r, key_ext=pend_ext, key_break=pend_brk; then clear both flags.
- Modifiers: 12 and 59 (non-ext) are left/right shift. Shift state = OR of both; make sets, break clears. Modifiers emit events but never touch held/count/repeat.
- Held tracking (held_code, held_ext, key_held):
  - Non-modifier make with key_held and matching {ext,code}: key_repeat=1, count unchanged.
  - Other non-modifier make: held := this key, key_held=1, press_count+1 (wraps at 2^CNT_W-1 -> 0).
  - Break matching held: key_held=0. Breaks of other keys: no held change.
- key_ascii: from the sub-module for non-ext, non-break events; uppercase letters when shift held; 0 otherwise.
- key_code/ext/break/repeat/ascii hold their value until the next event; key_valid is the only pulse.
- Prefix timeout: counter runs while pend_ext|pend_brk. On reaching PFX_TIMEOUT, clear both flags; err unchanged. Counter reset on every popped byte.
- kbd_overflow high any cycle: err=1; err cleared only by reset.
- Reset mid-POP: kbd_nextdata drops immediately; the byte is considered unpopped.

Decomposition:
- Package ps2_pkg:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_ACK=FA, SC_BAT=AA.
  - FSM state enum.
- Sub-module ps2_scan2ascii: combinational Set-2 -> ASCII ROM (a-z, 0-9, space 29, enter 5A) with a shift input.

Test Plan:
- Feed 1C with kbd_ready -> one nextdata pulse; next cycle key_valid=1, code=1C, ascii=61 ('a'), press_count=1, key_held=1.
- Feed 12,1C,F0,1C,F0,12 -> ascii=41 ('A') on the 1C make; the break events have ascii=0; final key_held=0, press_count=1.
- Feed E0,75 then E0,F0,75 -> events {ext=1,brk=0,code=75} and {ext=1,brk=1,code=75}; ascii=0; exactly two key_valid pulses total.
- Feed 1C,1C,1C (typematic) -> first repeat=0, next two repeat=1; press_count=1.
- Feed E0 then idle PFX_TIMEOUT+2 cycles, then 1C -> event ext=0; feed 00 -> err=1, no key_valid.
- Hold kbd_ready high with 4 queued bytes -> nextdata pulses spaced exactly 3 cycles apart. Assert rst low mid-stream -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants and sequencer state encoding for the PS/2 keyboard controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERRF   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 scan code to ASCII lookup; letters are uppercased while shift is held.
module ps2_scan2ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] base;

    always_comb begin
        base = 8'h00;
        case (code)
            8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
            8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
            8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
            8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
            8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
            8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
            8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
            8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
            8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
            8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
            8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
            8'h46: base = 8'h39;
            8'h29: base = 8'h20;
            8'h5A: base = 8'h0D;
            default: base = 8'h00;
        endcase
    end

    always_comb begin
        ascii = base;
        if (shift && base >= 8'h61 && base <= 8'h7A) begin
            ascii = base - 8'h20;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes into key events and
// tracks shift, held-key and press-count state for the console logic.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int          CNT_W       = 8,
    parameter logic [15:0] PFX_TIMEOUT = 16'd50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kbd_ready,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [CNT_W-1:0] press_count,
    output logic             err
);

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             lshift_q, lshift_d, rshift_q, rshift_d;
    logic             held_q, held_d, held_ext_q, held_ext_d;
    logic [7:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d, ext_q, ext_d, brk_q, brk_d, rep_q, rep_d;
    logic [7:0]       code_q, code_d, ascii_q, ascii_d;
    logic [7:0]       ascii_w;
    logic             is_mod;

    ps2_scan2ascii u_scan2ascii (
        .code  (byte_q),
        .shift (lshift_q | rshift_q),
        .ascii (ascii_w)
    );

    assign is_mod = !pend_ext_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        pend_ext_d   = pend_ext_q;
        pend_brk_d   = pend_brk_q;
        tmo_d        = tmo_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        held_d       = held_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        count_d      = count_q;
        err_d        = err_q | kbd_overflow;
        valid_d      = 1'b0;
        ext_d        = ext_q;
        brk_d        = brk_q;
        rep_d        = rep_q;
        code_d       = code_q;
        ascii_d      = ascii_q;
        kbd_nextdata = 1'b0;

        // A prefix left dangling by a lost code byte must not stick to the next key.
        if (pend_ext_q || pend_brk_q) begin
            if (tmo_q >= PFX_TIMEOUT) begin
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
                tmo_d      = 16'd0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = 16'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                kbd_nextdata = 1'b1;
                state_d      = ST_GAP;
                tmo_d        = 16'd0;
                pend_ext_d   = 1'b0;
                pend_brk_d   = 1'b0;
                case (byte_q)
                    SC_EXT: begin
                        pend_ext_d = 1'b1;
                        pend_brk_d = pend_brk_q;
                    end
                    SC_BRK: begin
                        pend_brk_d = 1'b1;
                        pend_ext_d = pend_ext_q;
                    end
                    SC_ERR0, SC_ERRF: err_d = 1'b1;
                    SC_ACK, SC_BAT, SC_PAUSE: ;
                    default: begin
                        valid_d = 1'b1;
                        code_d  = byte_q;
                        ext_d   = pend_ext_q;
                        brk_d   = pend_brk_q;
                        rep_d   = 1'b0;
                        ascii_d = (pend_ext_q || pend_brk_q) ? 8'h00 : ascii_w;
                        if (is_mod) begin
                            if (byte_q == SC_LSHIFT) lshift_d = !pend_brk_q;
                            else                     rshift_d = !pend_brk_q;
                        end else if (!pend_brk_q) begin
                            if (held_q && held_code_q == byte_q && held_ext_q == pend_ext_q) begin
                                rep_d = 1'b1;
                            end else begin
                                held_d      = 1'b1;
                                held_code_d = byte_q;
                                held_ext_d  = pend_ext_q;
                                count_d     = count_q + CNT_W'(1);
                            end
                        end else if (held_q && held_code_q == byte_q && held_ext_q == pend_ext_q) begin
                            held_d = 1'b0;
                        end
                    end
                endcase
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            pend_ext_q  <= 1'b0;
            pend_brk_q  <= 1'b0;
            tmo_q       <= 16'd0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            held_q      <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= 8'h00;
            count_q     <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            rep_q       <= 1'b0;
            code_q      <= 8'h00;
            ascii_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            pend_ext_q  <= pend_ext_d;
            pend_brk_q  <= pend_brk_d;
            tmo_q       <= tmo_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            held_q      <= held_d;
            held_ext_q  <= held_ext_d;
            held_code_q <= held_code_d;
            count_q     <= count_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            rep_q       <= rep_d;
            code_q      <= code_d;
            ascii_q     <= ascii_d;
        end
    end

    assign key_valid   = valid_q;
    assign key_code    = code_q;
    assign key_ext     = ext_q;
    assign key_break   = brk_q;
    assign key_repeat  = rep_q;
    assign key_ascii   = ascii_q;
    assign key_held    = held_q;
    assign press_count = count_q;
    assign err         = err_q;

endmodule
